// File: rtl/axil_prj_sel_ctrl.sv
// axil_prj_sel_ctrl: single-outstanding AXI-Lite bridge with project-select arbitration.
// Define AXIL_PRJ_SEL_TIMEOUT_EN to bound each downstream transaction to pTIMEOUT cycles.
module axil_prj_sel_ctrl #(
  parameter int pADDR_WIDTH = 15,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = 255
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset_n,
  input  logic                     s_awvalid,
  output logic                     s_awready,
  input  logic [pADDR_WIDTH-1:0]   s_awaddr,
  input  logic                     s_wvalid,
  output logic                     s_wready,
  input  logic [pDATA_WIDTH-1:0]   s_wdata,
  input  logic [pDATA_WIDTH/8-1:0] s_wstrb,
  input  logic                     s_arvalid,
  output logic                     s_arready,
  input  logic [pADDR_WIDTH-1:0]   s_araddr,
  output logic                     s_rvalid,
  input  logic                     s_rready,
  output logic [pDATA_WIDTH-1:0]   s_rdata,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [pADDR_WIDTH-1:0]   m_awaddr,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  output logic [pDATA_WIDTH-1:0]   m_wdata,
  output logic [pDATA_WIDTH/8-1:0] m_wstrb,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [pADDR_WIDTH-1:0]   m_araddr,
  input  logic                     m_rvalid,
  input  logic [pDATA_WIDTH-1:0]   m_rdata,
  output logic                     m_rready,
  input  logic                     sel_req_valid,
  input  logic [4:0]               sel_req,
  output logic                     sel_req_ready,
  output logic [4:0]               user_prj_sel,
  output logic                     busy,
  output logic                     timeout_err
);
  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, RD_RESP} state_t;
  state_t state;
  logic last_wr, idle, wr_go, rd_go, wr_done, expire;
  if (pTIMEOUT < 1 || pTIMEOUT > 255) begin : g_bad_timeout
    $error("pTIMEOUT must be in 1..255");
  end
  assign idle          = axi_reset_n && state == IDLE;
  assign sel_req_ready = idle && sel_req_valid;
  // on a write/read tie the type not granted last time wins
  assign wr_go         = idle && !sel_req_valid && s_awvalid && s_wvalid && !(s_arvalid && last_wr);
  assign rd_go         = idle && !sel_req_valid && s_arvalid && !wr_go;
  assign s_awready     = wr_go;
  assign s_wready      = wr_go;
  assign s_arready     = rd_go;
  assign m_arvalid     = state == RD_ADDR;
  assign m_rready      = state == RD_DATA;
  assign s_rvalid      = state == RD_RESP;
  assign busy          = state != IDLE;
  assign wr_done       = (!m_awvalid || m_awready) && (!m_wvalid || m_wready);
`ifdef AXIL_PRJ_SEL_TIMEOUT_EN
  localparam logic [7:0] LAST_CYCLE = 8'(pTIMEOUT - 1);
  logic [7:0] cnt;
  logic waiting;
  assign waiting = state == WR || state == RD_ADDR || state == RD_DATA;
  // a handshake landing on the expiry cycle completes normally
  assign expire = cnt >= LAST_CYCLE &&
                  (state == WR ? !wr_done : state == RD_ADDR ? !m_arready : state == RD_DATA && !m_rvalid);
  always_ff @(posedge axi_clk) begin
    cnt         <= (!axi_reset_n || wr_go || rd_go) ? 8'd0 : waiting ? cnt + 8'd1 : cnt;
    timeout_err <= axi_reset_n && expire;
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      state        <= IDLE;
      last_wr      <= 1'b0;
      user_prj_sel <= '0;
      m_awvalid    <= 1'b0;
      m_wvalid     <= 1'b0;
      m_awaddr     <= '0;
      m_wdata      <= '0;
      m_wstrb      <= '0;
      m_araddr     <= '0;
      s_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_req_ready) user_prj_sel <= sel_req;
          if (wr_go) begin
            m_awaddr  <= s_awaddr;
            m_wdata   <= s_wdata;
            m_wstrb   <= s_wstrb;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
            last_wr   <= 1'b1;
            state     <= WR;
          end
          if (rd_go) begin
            m_araddr <= s_araddr;
            last_wr  <= 1'b0;
            state    <= RD_ADDR;
          end
        end
        WR: begin
          if (m_awready || expire) m_awvalid <= 1'b0;
          if (m_wready || expire) m_wvalid <= 1'b0;
          if (wr_done || expire) state <= IDLE;
        end
        RD_ADDR: begin
          if (m_arready) state <= RD_DATA;
          else if (expire) begin
            s_rdata <= '1;
            state   <= RD_RESP;
          end
        end
        RD_DATA: begin
          if (m_rvalid || expire) begin
            s_rdata <= m_rvalid ? m_rdata : '1;
            state   <= RD_RESP;
          end
        end
        RD_RESP: if (s_rready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_prj_sel_ctrl.sv
// tb_axil_prj_sel_ctrl: arbitration vectors, directed corner sequences and randomized transactions.
module tb_axil_prj_sel_ctrl;
  localparam int AW = 15, DW = 32, TO = 8;
  logic axi_clk = 1'b0, axi_reset_n;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic [DW-1:0] s_wdata, s_rdata, m_wdata, m_rdata;
  logic [DW/8-1:0] s_wstrb, m_wstrb;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic sel_req_valid, sel_req_ready, busy, timeout_err;
  logic [4:0] sel_req, user_prj_sel;
  always #5 axi_clk = ~axi_clk;
  axil_prj_sel_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pTIMEOUT(TO)) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
    .sel_req_valid(sel_req_valid), .sel_req(sel_req), .sel_req_ready(sel_req_ready),
    .user_prj_sel(user_prj_sel), .busy(busy), .timeout_err(timeout_err)
  );
  typedef struct {
    logic sv; logic [4:0] sel; logic awv, wv, arv;
    logic e_sel, e_wr, e_rd; logic [4:0] e_prj;
  } vec_t;
  vec_t tbl[11];
  int errors = 0, checks = 0;
  int da, dw, dr, ds, mx;
  logic model_last_wr;
  logic [4:0] model_prj;
  logic sv, awv, wv, arv, e_wr, e_rd;
  logic [4:0] sl;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd, wd;
  logic [DW/8-1:0] ws;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick; @(posedge axi_clk); #1; endtask
  task automatic look; @(negedge axi_clk); endtask
  task automatic up_idle;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; sel_req_valid = 0;
  endtask
  task automatic do_reset;
    axi_reset_n = 0; tick; tick; axi_reset_n = 1;
    model_last_wr = 0; model_prj = 0;
  endtask
  initial begin
    up_idle; sel_req = 0; s_awaddr = 0; s_araddr = 0; s_wdata = 0; s_wstrb = 0; s_rready = 1;
    m_awready = 1; m_wready = 1; m_arready = 1; m_rvalid = 1; m_rdata = 0;
    axi_reset_n = 0; tick;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; sel_req_valid = 1;
    tick; look;
    chk("rst busy", busy, 0); chk("rst prj", user_prj_sel, 0);
    chk("rst awready", s_awready, 0); chk("rst arready", s_arready, 0);
    chk("rst sel_ready", sel_req_ready, 0); chk("rst m_awvalid", m_awvalid, 0);
    chk("rst m_wvalid", m_wvalid, 0); chk("rst s_rvalid", s_rvalid, 0);
    chk("rst s_rdata", s_rdata, 0); chk("rst timeout_err", timeout_err, 0);
    up_idle; tick; axi_reset_n = 1; tick;
    // arbitration vectors, starting with last grant = read
    tbl[0]  = '{0, 5'd0, 1, 0, 0, 0, 0, 0, 5'd0};
    tbl[1]  = '{0, 5'd0, 0, 1, 0, 0, 0, 0, 5'd0};
    tbl[2]  = '{1, 5'd5, 1, 1, 1, 1, 0, 0, 5'd5};
    tbl[3]  = '{0, 5'd0, 1, 1, 1, 0, 1, 0, 5'd5};
    tbl[4]  = '{0, 5'd0, 1, 1, 1, 0, 0, 1, 5'd5};
    tbl[5]  = '{0, 5'd0, 0, 0, 1, 0, 0, 1, 5'd5};
    tbl[6]  = '{0, 5'd0, 1, 1, 1, 0, 1, 0, 5'd5};
    tbl[7]  = '{0, 5'd0, 1, 1, 0, 0, 1, 0, 5'd5};
    tbl[8]  = '{0, 5'd0, 1, 1, 1, 0, 0, 1, 5'd5};
    tbl[9]  = '{0, 5'd9, 0, 0, 0, 0, 0, 0, 5'd5};
    tbl[10] = '{1, 5'd0, 0, 0, 1, 1, 0, 0, 5'd0};
    for (int i = 0; i < 11; i++) begin
      sel_req_valid = tbl[i].sv; sel_req = tbl[i].sel;
      s_awvalid = tbl[i].awv; s_wvalid = tbl[i].wv; s_arvalid = tbl[i].arv;
      s_awaddr = AW'(i * 4); s_araddr = AW'(i * 8); s_wdata = $urandom;
      look;
      chk($sformatf("vec%0d sel_ready", i), sel_req_ready, tbl[i].e_sel);
      chk($sformatf("vec%0d awready", i), s_awready, tbl[i].e_wr);
      chk($sformatf("vec%0d wready", i), s_wready, tbl[i].e_wr);
      chk($sformatf("vec%0d arready", i), s_arready, tbl[i].e_rd);
      tick; up_idle;
      repeat (6) tick;
      look;
      chk($sformatf("vec%0d prj", i), user_prj_sel, tbl[i].e_prj);
      chk($sformatf("vec%0d busy", i), busy, 0);
      tick;
    end
    // minimum-latency write
    s_awvalid = 1; s_wvalid = 1; s_awaddr = 15'h0123; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'hF;
    look; chk("w38 awready", s_awready, 1); tick; up_idle;
    look;
    chk("w38 m_awvalid", m_awvalid, 1); chk("w38 m_wvalid", m_wvalid, 1);
    chk("w38 m_awaddr", m_awaddr, 15'h0123); chk("w38 m_wdata", m_wdata, 32'hA5A5A5A5);
    chk("w38 busy", busy, 1);
    tick; look;
    chk("w38 m_awvalid drop", m_awvalid, 0); chk("w38 m_wvalid drop", m_wvalid, 0);
    chk("w38 busy drop", busy, 0);
    tick;
    // minimum-latency read
    s_arvalid = 1; s_araddr = 15'h0040; m_rdata = 32'hDEADBEEF;
    look; chk("r39 arready", s_arready, 1); tick; up_idle;
    look; chk("r39 m_arvalid", m_arvalid, 1); chk("r39 m_araddr", m_araddr, 15'h0040); tick;
    look; chk("r39 m_rready", m_rready, 1); chk("r39 s_rvalid early", s_rvalid, 0); tick;
    look; chk("r39 s_rvalid", s_rvalid, 1); chk("r39 s_rdata", s_rdata, 32'hDEADBEEF); tick;
    look; chk("r39 busy", busy, 0); tick;
    // write/read tie alternates from reset
    do_reset;
    for (int r = 0; r < 4; r++) begin
      s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
      look;
      chk($sformatf("rr%0d write", r), s_awready, (r % 2) == 0);
      chk($sformatf("rr%0d read", r), s_arready, (r % 2) == 1);
      tick; up_idle;
      repeat (5) tick;
    end
    // select request held while a read is pending
    m_arready = 0; s_arvalid = 1; s_araddr = 15'h0011; m_rdata = 32'h1234_5678;
    look; tick; up_idle;
    sel_req_valid = 1; sel_req = 5'd2;
    for (int k = 0; k < 3; k++) begin
      look; chk("s41 held ready", sel_req_ready, 0); chk("s41 held prj", user_prj_sel, 0); tick;
    end
    m_arready = 1;
    for (int k = 0; k < 3; k++) begin
      look; chk("s41 busy ready", sel_req_ready, 0); tick;
    end
    look; chk("s41 ready", sel_req_ready, 1); chk("s41 prj before", user_prj_sel, 0); tick;
    sel_req_valid = 0;
    look; chk("s41 prj", user_prj_sel, 2); tick;
    // reset in the middle of a write
    sel_req_valid = 1; sel_req = 5'd7; tick; up_idle;
    m_wready = 0;
    s_awvalid = 1; s_wvalid = 1; s_wdata = 32'h0BAD_F00D;
    look; chk("r43 awready", s_awready, 1); tick; up_idle;
    look; chk("r43 m_wvalid", m_wvalid, 1); tick;
    look; chk("r43 still busy", busy, 1);
    axi_reset_n = 0; tick; axi_reset_n = 1;
    look;
    chk("r43 m_wvalid", m_wvalid, 0); chk("r43 m_awvalid", m_awvalid, 0);
    chk("r43 busy", busy, 0); chk("r43 prj", user_prj_sel, 0);
    tick; m_wready = 1;
    // stuck downstream read address
    m_arready = 0; s_arvalid = 1;
    look; chk("t42 arready", s_arready, 1); tick; up_idle;
`ifdef AXIL_PRJ_SEL_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      look; chk("t42 m_arvalid", m_arvalid, 1); chk("t42 no err", timeout_err, 0); tick;
    end
    look;
    chk("t42 err", timeout_err, 1); chk("t42 s_rvalid", s_rvalid, 1);
    chk("t42 s_rdata", s_rdata, 32'hFFFFFFFF); chk("t42 m_arvalid drop", m_arvalid, 0);
    tick; look; chk("t42 err pulse", timeout_err, 0); chk("t42 busy", busy, 0); tick;
    m_arready = 1;
`else
    for (int k = 0; k < 20; k++) begin
      look; chk("nt m_arvalid", m_arvalid, 1); chk("nt err", timeout_err, 0); tick;
    end
    m_arready = 1; repeat (4) tick;
    look; chk("nt busy", busy, 0); tick;
`endif
    // randomized transactions against the reference model
    do_reset;
    m_awready = 0; m_wready = 0; m_arready = 0; m_rvalid = 0; s_rready = 0;
    for (int t = 0; t < 150; t++) begin
      sv = $urandom_range(3) == 0; sl = 5'($urandom);
      awv = 1'($urandom_range(1)); wv = 1'($urandom_range(1)); arv = 1'($urandom_range(1));
      ra = AW'($urandom); wd = $urandom; ws = 4'($urandom); rd = $urandom;
      e_wr = !sv && awv && wv && (!arv || !model_last_wr);
      e_rd = !sv && arv && !e_wr;
      sel_req_valid = sv; sel_req = sl; s_awvalid = awv; s_wvalid = wv; s_arvalid = arv;
      s_awaddr = ra; s_araddr = ra; s_wdata = wd; s_wstrb = ws;
      look;
      chk("rnd sel_ready", sel_req_ready, sv);
      chk("rnd awready", s_awready, e_wr);
      chk("rnd wready", s_wready, e_wr);
      chk("rnd arready", s_arready, e_rd);
      tick; up_idle;
      if (sv) model_prj = sl;
      if (e_wr) begin
        model_last_wr = 1;
        da = $urandom_range(2); dw = $urandom_range(2); mx = da > dw ? da : dw;
        for (int k = 0; k <= mx; k++) begin
          m_awready = k == da; m_wready = k == dw;
          look;
          chk("rnd m_awvalid", m_awvalid, k <= da); chk("rnd m_wvalid", m_wvalid, k <= dw);
          chk("rnd m_awaddr", m_awaddr, ra); chk("rnd m_wdata", m_wdata, wd);
          chk("rnd m_wstrb", m_wstrb, ws); chk("rnd wr busy", busy, 1);
          tick;
        end
        m_awready = 0; m_wready = 0;
      end
      if (e_rd) begin
        model_last_wr = 0;
        da = $urandom_range(2); dr = $urandom_range(2); ds = $urandom_range(2);
        for (int k = 0; k <= da; k++) begin
          m_arready = k == da;
          look; chk("rnd m_arvalid", m_arvalid, 1); chk("rnd m_araddr", m_araddr, ra); tick;
        end
        m_arready = 0;
        for (int k = 0; k <= dr; k++) begin
          m_rvalid = k == dr; m_rdata = k == dr ? rd : ~rd;
          look; chk("rnd m_rready", m_rready, 1); chk("rnd m_arvalid low", m_arvalid, 0); tick;
        end
        m_rvalid = 0;
        for (int k = 0; k <= ds; k++) begin
          s_rready = k == ds;
          look; chk("rnd s_rvalid", s_rvalid, 1); chk("rnd s_rdata", s_rdata, rd); tick;
        end
        s_rready = 0;
      end
      look;
      chk("rnd idle", busy, 0); chk("rnd prj", user_prj_sel, model_prj);
      chk("rnd err", timeout_err, 0);
      tick;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axil_prj_sel_ctrl.md
AXIL_PRJ_SEL_CTRL -- requirements
Module: axil_prj_sel_ctrl

Interface
REQ-001 Parameter pADDR_WIDTH, default 15, SHALL set the upstream and downstream address width.
REQ-002 Parameter pDATA_WIDTH, default 32, SHALL set the data width; the strobe width SHALL be pDATA_WIDTH/8.
REQ-003 Parameter pTIMEOUT, default 255, SHALL set the per-transaction cycle budget, range 1..255.
REQ-004 axi_clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-005 axi_reset_n  in  1  reset, synchronous, active-low.
REQ-006 s_awvalid/s_awready  in/out  1  upstream write-address handshake; s_awaddr in pADDR_WIDTH.
REQ-007 s_wvalid/s_wready  in/out  1  upstream write-data handshake; s_wdata in pDATA_WIDTH; s_wstrb in 4.
REQ-008 s_arvalid/s_arready  in/out  1  upstream read-address handshake; s_araddr in pADDR_WIDTH.
REQ-009 s_rvalid/s_rready  out/in  1  upstream read-data handshake; s_rdata out pDATA_WIDTH.
REQ-010 m_awvalid/m_awready, m_wvalid/m_wready, m_arvalid/m_arready  out/in  1  downstream handshakes toward the project mux.
REQ-011 m_awaddr, m_araddr  out  pADDR_WIDTH; m_wdata  out  pDATA_WIDTH; m_wstrb  out  4.
REQ-012 m_rvalid  in  1; m_rdata  in  pDATA_WIDTH; m_rready  out  1.
REQ-013 sel_req_valid  in  1; sel_req  in  5; sel_req_ready  out  1: project-select change request.
REQ-014 user_prj_sel  out  5  registered project select driven to the mux.
REQ-015 busy  out  1  high whenever the FSM is not IDLE.
REQ-016 timeout_err  out  1  one-cycle pulse on a transaction abort.

Function
REQ-017 FSM states SHALL be: IDLE, WR, RD_ADDR, RD_DATA and RD_RESP; exactly one transaction SHALL be in flight.
REQ-018 IDLE priority SHALL be: sel_req_valid first, then round-robin between write (s_awvalid AND s_wvalid) and read (s_arvalid).
REQ-019 Select grant SHALL set user_prj_sel<=sel_req and sel_req_ready=1 in that cycle, with no state change; it SHALL be acknowledged even if sel_req equals the current value.
REQ-020 sel_req_valid outside IDLE SHALL be held with sel_req_ready=0; user_prj_sel SHALL never change outside IDLE.
REQ-021 Write grant: s_awready=s_wready=1 combinationally for one cycle; capture awaddr, wdata and wstrb; next state WR.
REQ-022 s_awvalid without s_wvalid, or the reverse, SHALL NOT be granted.
REQ-023 WR: m_awvalid and m_wvalid SHALL be driven from the captured registers.
REQ-024 In WR, each valid SHALL drop the cycle after its own ready; the FSM SHALL return to IDLE when both have handshaked, with same-cycle readies giving a one-cycle WR.
REQ-025 Read grant: s_arready=1 for one cycle; capture araddr; next state RD_ADDR.
REQ-026 RD_ADDR: m_arvalid=1 until m_arready, then RD_DATA.
REQ-027 RD_DATA: m_rready=1; on m_rvalid, capture m_rdata and go to RD_RESP.
REQ-028 RD_RESP: s_rvalid=1 with s_rdata held until s_rready, then IDLE.
REQ-029 Round-robin: last_grant SHALL update on each write or read grant; on a tie, the type not last granted SHALL win.
REQ-030 Downstream valids SHALL never be asserted in IDLE; upstream readies SHALL be pulses in IDLE only.
REQ-031 Minimum latency: write SHALL take 2 cycles from grant to IDLE; read SHALL have s_rvalid 3 cycles after s_arready.

Reset
REQ-032 On axi_reset_n=0 at a clock edge: state=IDLE, user_prj_sel=0, last_grant=read, counter=0, captured registers=0, and all outputs 0.
REQ-033 Reset mid-transaction SHALL abort it; downstream valids SHALL be low the cycle after the reset edge, with no completion issued.

Configuration
REQ-034 Macro AXIL_PRJ_SEL_TIMEOUT_EN defined: an 8-bit counter SHALL clear on write or read grant and increment in WR, RD_ADDR and RD_DATA.
REQ-035 With the macro defined, when the counter reaches pTIMEOUT: drop downstream valids and m_rready, pulse timeout_err, and go to IDLE from WR or to RD_RESP with s_rdata=0xFFFFFFFF.
REQ-036 With the macro defined, a ready or m_rvalid in the same cycle as expiry SHALL win, and no timeout_err SHALL be issued.
REQ-037 Macro undefined: no counter; waits SHALL be unbounded; timeout_err SHALL be tied 0.

Verification
REQ-038 Write 0x0123/0xA5A5A5A5 with m_awready and m_wready high -> m_awaddr=0x0123, m_wdata=0xA5A5A5A5 for one cycle, busy 1 cycle.
REQ-039 Read 0x0040, m_rvalid with m_rdata=0xDEADBEEF one cycle after m_arready -> s_rdata=0xDEADBEEF, s_rvalid 3 cycles after s_arready.
REQ-040 Write and read requested together for 4 back-to-back rounds after reset -> grants W,R,W,R.
REQ-041 sel_req_valid=1, sel_req=2 during a pending read -> sel_req_ready low until IDLE, then user_prj_sel=2 in the following cycle.
REQ-042 Macro defined, pTIMEOUT=8, m_arready stuck low -> timeout_err pulse after 8 cycles, then s_rvalid with 0xFFFFFFFF.
REQ-043 Reset asserted in WR with m_wready low -> m_wvalid=0 and busy=0 after the reset edge, and user_prj_sel=0.
